// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM (1-cycle read latency) with locked bursts.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise m1 wins every tie (fixed priority).
module mem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    localparam int unsigned   CW      = $clog2(MAX_BURST + 1);
    localparam logic          LOCK_EN = (MAX_BURST > 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] burst_cnt, burst_cnt_nxt;
    logic          last, last_nxt;       // 0 = m0 owned the latest grant, 1 = m1
    logic          gnt0, gnt1;
    logic          lock_active;
    logic          tie_m1;

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        last_nxt      = last;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        lock_active   = 1'b0;
`ifdef MEM_ARB_RR_EN
        tie_m1        = ~last;
`else
        tie_m1        = 1'b1;
`endif
        case (state)
            LOCK0:   lock_active = m0_lock && (burst_cnt < CNT_MAX);
            LOCK1:   lock_active = m1_lock && (burst_cnt < CNT_MAX);
            default: lock_active = 1'b0;
        endcase

        if (lock_active) begin
            gnt0 = (state == LOCK0) && m0_req;
            gnt1 = (state == LOCK1) && m1_req;
            if (gnt0 || gnt1)
                burst_cnt_nxt = burst_cnt + 1'b1;
        end else begin
            // An expired lock arbitrates exactly like ARB in the same cycle.
            if (m0_req && m1_req) begin
                gnt1 = tie_m1;
                gnt0 = ~tie_m1;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
            if (gnt0 && m0_lock && LOCK_EN) begin
                state_nxt     = LOCK0;
                burst_cnt_nxt = CW'(1);
            end else if (gnt1 && m1_lock && LOCK_EN) begin
                state_nxt     = LOCK1;
                burst_cnt_nxt = CW'(1);
            end else begin
                state_nxt     = ARB;
                burst_cnt_nxt = '0;
            end
        end

        if (gnt0)
            last_nxt = 1'b0;
        else if (gnt1)
            last_nxt = 1'b1;
    end

    // Grants are masked while reset is high so an async reset silences the RAM immediately.
    assign m0_gnt = gnt0 & ~rst;
    assign m1_gnt = gnt1 & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            burst_cnt <= '0;
            last      <= 1'b1;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            last      <= last_nxt;
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
        end
    end

    always_comb begin
        ram_address = m0_addr;
        ram_data    = m0_wdata;
        ram_wren    = 1'b0;
        if (m1_gnt) begin
            ram_address = m1_addr;
            ram_data    = m1_wdata;
            ram_wren    = m1_we;
        end else if (m0_gnt) begin
            ram_wren    = m0_we;
        end
    end

    assign m0_rdata = ram_q;
    assign m1_rdata = ram_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (owner/burst/last bookkeeping and a shadow memory).
module tb_mem_arbiter;

    localparam int MAXB = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_wren;
    logic [31:0] m0_rdata, m1_rdata, ram_address, ram_data, ram_q;

    int total, bad;

    mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'hDEADBEEF;
        return 32'hC0DE0000 + 32'(i) * 32'h00000101;
    endfunction

    // RAM macro: 256 words, write-enable, 1-cycle registered read.
    logic [31:0] ram_arr [0:255];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_arr[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (ram_wren) begin
            ram_arr[ram_address[7:0]] <= ram_data;
        end
        ram_q <= ram_arr[ram_address[7:0]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          m_owner, m_cnt, m_last;
    bit          m_rv0, m_rv1;
    logic [31:0] m_rd0, m_rd1;

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
    endtask

    function automatic bit model_locked();
        if (m_owner == 0) return m0_lock && (m_cnt < MAXB);
        if (m_owner == 1) return m1_lock && (m_cnt < MAXB);
        return 1'b0;
    endfunction

    function automatic int model_pick();
        if (model_locked()) begin
            if (m_owner == 0) return m0_req ? 0 : -1;
            return m1_req ? 1 : -1;
        end
        if (m0_req && m1_req) return RR ? ((m_last == 0) ? 1 : 0) : 1;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    task automatic model_update();
        int g;
        bit lk;
        lk = model_locked();
        g  = model_pick();
        m_rv0 = 0; m_rv1 = 0;
        if (g == 0) begin
            m_last = 0;
            if (m0_we) ref_mem[m0_addr[7:0]] = m0_wdata;
            else begin m_rv0 = 1; m_rd0 = ref_mem[m0_addr[7:0]]; end
        end else if (g == 1) begin
            m_last = 1;
            if (m1_we) ref_mem[m1_addr[7:0]] = m1_wdata;
            else begin m_rv1 = 1; m_rd1 = ref_mem[m1_addr[7:0]]; end
        end
        if (lk) begin
            if (g >= 0) m_cnt++;
        end else if (g >= 0 && MAXB > 1 && ((g == 0) ? m0_lock : m1_lock)) begin
            m_owner = g; m_cnt = 1;
        end else begin
            m_owner = -1; m_cnt = 0;
        end
    endtask

    // Advance one clock; inputs are stable from here to the edge, outputs settle 1 unit after it.
    task automatic step();
        if (rst) model_reset(); else model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 32'h33; m0_wdata = 32'h0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 32'h44; m1_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1; model_reset();
        m0_req = 1; m1_req = 1;
        #3;
        total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        step(); step();
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        rst = 0; set_idle();
        #2;
        total++; if ({m0_gnt, m1_gnt, ram_wren} !== 3'b000) begin bad++; $display("FAIL idle_gnt: got %b want 000", {m0_gnt, m1_gnt, ram_wren}); end
        total++; if (ram_address !== 32'h33) begin bad++; $display("FAIL idle_addr: got %h want 00000033", ram_address); end
        step();
    endtask

    task automatic test_read_latency();
        set_idle(); m0_req = 1; m0_addr = 32'h10;
        #2;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL rd_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        total++; if (ram_address !== 32'h10 || ram_wren !== 1'b0) begin bad++; $display("FAIL rd_ram: got addr=%h wren=%b want 10/0", ram_address, ram_wren); end
        step();
        m0_req = 0;
        #2;
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin bad++; $display("FAIL rd_rvalid: got %b want 10", {m0_rvalid, m1_rvalid}); end
        total++; if (m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", m0_rdata); end
        step();
    endtask

    task automatic test_tie_break();
        bit exp1, prev0, prev1;
        prev0 = 0; prev1 = 0;
        set_idle(); m0_req = 1; m1_req = 1;
        for (int k = 0; k < 8; k++) begin
            m0_addr = 32'(8 + k); m1_addr = 32'(24 + k);
            #2;
            exp1 = RR ? (k % 2 == 0) : 1'b1;   // last was m0 after the previous test
            total++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin bad++; $display("FAIL tie_gnt[%0d]: got %b want %b", k, {m0_gnt, m1_gnt}, {~exp1, exp1}); end
            total++; if ({m0_rvalid, m1_rvalid} !== {prev0, prev1}) begin bad++; $display("FAIL tie_rvalid[%0d]: got %b want %b", k, {m0_rvalid, m1_rvalid}, {prev0, prev1}); end
            prev0 = ~exp1; prev1 = exp1;
            step();
        end
        set_idle(); step();
    endtask

    task automatic test_locked_burst();
        bit exp1;
        int w;
        w = 0;
        set_idle(); m0_req = 1; m0_addr = 32'h11; m1_we = 1;
        for (int k = 0; k < 22; k++) begin
            m1_req = (w < 20); m1_lock = (w < 20);
            m1_addr = 32'h40 + 32'(w); m1_wdata = 32'hB0000000 + 32'(w);
            #2;
            exp1 = RR ? ((k < 16) || (k >= 17 && k < 21)) : (k < 20);
            total++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin bad++; $display("FAIL burst_gnt[%0d]: got %b want %b", k, {m0_gnt, m1_gnt}, {~exp1, exp1}); end
            total++; if (ram_wren !== exp1) begin bad++; $display("FAIL burst_wren[%0d]: got %b want %b", k, ram_wren, exp1); end
            if (m1_gnt) w++;
            step();
        end
        total++; if (w !== 20) begin bad++; $display("FAIL burst_words: got %0d want 20", w); end
        set_idle(); step();
    endtask

    task automatic test_lock_idle();
        set_idle(); m1_req = 1; m1_lock = 1; m1_addr = 32'h41;
        #2;
        total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL lkidle_take: got %b want 01", {m0_gnt, m1_gnt}); end
        step();
        m1_req = 0; m0_req = 1; m0_addr = 32'h10;
        for (int k = 0; k < 3; k++) begin
            #2;
            total++; if ({m0_gnt, m1_gnt, ram_wren} !== 3'b000) begin bad++; $display("FAIL lkidle_stall[%0d]: got %b want 000", k, {m0_gnt, m1_gnt, ram_wren}); end
            if (k == 0) begin
                total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB0000001) begin bad++; $display("FAIL lkidle_rdata: got %b/%h want 1/b0000001", m1_rvalid, m1_rdata); end
            end
            step();
        end
        m1_lock = 0;
        #2;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL lkidle_release: got %b want 10", {m0_gnt, m1_gnt}); end
        step();
        set_idle(); step();
    endtask

    task automatic test_async_reset();
        bit exp1;
        set_idle(); m1_req = 1; m1_lock = 1; m1_addr = 32'h42;
        #2;
        total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL arst_take: got %b want 1", m1_gnt); end
        step();
        m0_req = 1; m0_addr = 32'h12;
        #1;
        total++; if ({m1_gnt, m1_rvalid} !== 2'b11) begin bad++; $display("FAIL arst_pre: got %b want 11", {m1_gnt, m1_rvalid}); end
        #1 rst = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin bad++; $display("FAIL arst_now: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
        step();
        total++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wren} !== 5'b00000) begin bad++; $display("FAIL arst_hold: got %b want 00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wren}); end
        rst = 0;
        m1_lock = 0;
        #2;
        exp1 = RR ? 1'b0 : 1'b1;
        total++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin bad++; $display("FAIL arst_tie: got %b want %b", {m0_gnt, m1_gnt}, {~exp1, exp1}); end
        step();
        set_idle(); step();
    endtask

    task automatic test_write_path();
        set_idle(); m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h1234;
        #2;
        total++; if ({m0_gnt, ram_wren} !== 2'b11) begin bad++; $display("FAIL wr_gnt: got %b want 11", {m0_gnt, ram_wren}); end
        total++; if (ram_address !== 32'h20 || ram_data !== 32'h1234) begin bad++; $display("FAIL wr_bus: got %h/%h want 20/1234", ram_address, ram_data); end
        step();
        m0_we = 0;
        #2;
        total++; if ({ram_wren, m0_rvalid} !== 2'b00) begin bad++; $display("FAIL wr_once: got %b want 00", {ram_wren, m0_rvalid}); end
        step();
        m0_req = 0;
        #2;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234 || ram_wren !== 1'b0) begin bad++; $display("FAIL wr_readback: got %b/%h/%b want 1/00001234/0", m0_rvalid, m0_rdata, ram_wren); end
        step();
    endtask

    task automatic test_random();
        int g;
        int lkp;
        g = -1;
        set_idle();
        for (int n = 0; n < 400; n++) begin
            lkp = (n < 200) ? 7 : 2;
            if (!(m0_req && g != 0)) begin
                m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
                m0_lock = ($urandom_range(0, 7) < 2); m0_addr = $urandom_range(0, 255); m0_wdata = $urandom;
            end
            if (!(m1_req && g != 1)) begin
                m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom_range(0, 1));
                m1_lock = ($urandom_range(0, 7) < lkp); m1_addr = $urandom_range(0, 255); m1_wdata = $urandom;
            end
            #2;
            g = model_pick();
            total++; if ({m0_gnt, m1_gnt} !== {g == 0, g == 1}) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, {m0_gnt, m1_gnt}, {g == 0, g == 1}); end
            total++; if (ram_wren !== ((g == 0) ? m0_we : (g == 1) ? m1_we : 1'b0)) begin bad++; $display("FAIL rnd_wren[%0d]: got %b", n, ram_wren); end
            total++; if (ram_address !== ((g == 1) ? m1_addr : m0_addr) || ram_data !== ((g == 1) ? m1_wdata : m0_wdata)) begin bad++; $display("FAIL rnd_bus[%0d]: got %h/%h", n, ram_address, ram_data); end
            total++; if ({m0_rvalid, m1_rvalid} !== {m_rv0, m_rv1}) begin bad++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, {m0_rvalid, m1_rvalid}, {m_rv0, m_rv1}); end
            if (m_rv0) begin
                total++; if (m0_rdata !== m_rd0) begin bad++; $display("FAIL rnd_rdata0[%0d]: got %h want %h", n, m0_rdata, m_rd0); end
            end
            if (m_rv1) begin
                total++; if (m1_rdata !== m_rd1) begin bad++; $display("FAIL rnd_rdata1[%0d]: got %h want %h", n, m1_rdata, m_rd1); end
            end
            step();
        end
        set_idle(); step();
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        set_idle();
        test_reset();
        test_read_latency();
        test_tie_break();
        test_locked_burst();
        test_lock_idle();
        test_async_reset();
        test_write_path();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous RAM (1-cycle read latency) between two requesters: m0 = CPU core (fetch + load/store), m1 = UART loader/debug port.
- Arbitrates per cycle, with an optional locked burst so m1 can stream a program image without interleaving.
- Sits between the requesters and the RAM macro.
- All RAM-side signals are driven from the grant mux.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_BURST, 16, max consecutive locked grants to one master (>=1); counter width = clog2(MAX_BURST+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
m0_req  in  1  m0 requests a transfer this cycle
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  m0 asks to keep ownership after this grant
m0_addr  in  AW  word address
m0_wdata  in  DW  write data
m0_gnt  out  1  transfer accepted this cycle (combinational)
m0_rvalid  out  1  read data valid (registered pulse)
m0_rdata  out  DW  read data, equals ram_q
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for m1
ram_address  out  AW  to RAM address
ram_data  out  DW  to RAM write data
ram_wren  out  1  to RAM write enable
ram_q  in  DW  RAM read data, valid the cycle after the address edge

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. Reset values: state=ARB, burst_cnt=0, last=m1 (so m0 wins the first tie), m0_rvalid=m1_rvalid=0.
- Handshake: a transfer happens in the cycle where req&gnt=1. A requester holds addr/we/wdata/lock stable while req=1 and gnt=0. At most one gnt per cycle. gnt never rises without req.
- RAM mux: when a grant is given, ram_address/ram_data/ram_wren come from the granted master. With no grant: ram_wren=0, ram_address=m0_addr, ram_data=m0_wdata.
- Read latency: a read granted in cycle N gives mX_rvalid=1 in cycle N+1 with mX_rdata=ram_q. Writes never produce rvalid. Back-to-back grants sustain one transfer per cycle. rdata is don't-care when rvalid=0.
- States: ARB, LOCK0, LOCK1.
- ARB:
  - Only one master requesting: that master is granted.
  - Both requesting: the master that is not `last` is granted (round robin).
  - Neither requesting: no grant.
- Register updates on a grant to X (any state): last<=X.
- Entering a lock, from ARB or from an expired lock: if X_lock=1 and MAX_BURST>1, next state = LOCKX and burst_cnt<=1.
- LOCKX, while X_lock=1 and burst_cnt<MAX_BURST:
  - Only X may be granted.
  - X_req=1: grant X, burst_cnt++.
  - X_req=0: no grant; the other master stalls.
- LOCKX, when X_lock=0 or burst_cnt==MAX_BURST:
  - Expires this cycle; arbitration behaves exactly as ARB in the same cycle.
  - last==X, so the other master wins a tie. A burst-limited master therefore cannot starve the other.
  - If nobody is granted, next state = ARB and burst_cnt<=0.
- MAX_BURST=1: lock inputs are ignored and LOCK states are never entered.
- Reset mid-burst or mid-read: state returns to ARB immediately and any pending rvalid is dropped. A read granted in the cycle before reset asserts gets no rvalid.
- Simultaneous events: if both masters request with lock=1, only the winner enters a lock.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin tie-break as described above.
- Undefined: fixed priority. m1 wins every tie in ARB and at lock expiry. `last` is still tracked but not used for ties. Lock behaviour is unchanged.

Test Plan:
- Read latency: after reset, m0 reads addr 0x10 (RAM holds 0xDEADBEEF) -> m0_gnt=1 in cycle N; m0_rvalid=1 with m0_rdata=0xDEADBEEF in N+1; m1_rvalid stays 0.
- Tie-break: m0 and m1 both hold req continuously with reads, lock=0 -> grants alternate m0,m1,m0,m1 (RR_EN). Without the macro -> m1 granted every cycle.
- Locked burst: m1 writes 20 words with lock=1, MAX_BURST=16, while m0 reads continuously -> m1 granted 16 consecutive cycles; m0 granted on the 17th; m1 resumes after.
- Lock with idle owner: m1 lock=1 with req dropped for 3 cycles while m0 requests -> no grants for 3 cycles; m1 drops lock -> m0 granted the same cycle.
- Async reset mid-burst: assert rst asynchronously (mid-cycle) during LOCK1 with a read in flight -> all gnt/rvalid=0 immediately. After release, the first tie goes to m0.
- Write path: m0 writes 0x1234 to 0x20, then reads 0x20 -> ram_wren=1 for one cycle only; the read returns 0x1234; no rvalid for the write.
